// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with one-word blocks.
// Hits answer combinationally; misses stall the requester; halt flushes all dirty lines.
module dcache_responder #(
    parameter int SETS   = 8,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    input  logic              halt,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              flushed,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    input  logic              dwait,
    input  logic [WORD_W-1:0] dload
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WB    = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state, next_state;
    logic [SETS-1:0]   valid, dirty;
    logic [TAG_W-1:0]  tag_arr  [SETS];
    logic [WORD_W-1:0] data_arr [SETS];
    logic [IDX_W-1:0]  flush_idx;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req, hit, victim_dirty, flush_dirty, flush_step;
    logic              unused_addr_bits;

    assign req_idx          = dmemaddr[IDX_W+1:2];
    assign req_tag          = dmemaddr[WORD_W-1:IDX_W+2];
    assign unused_addr_bits = ^dmemaddr[1:0];

    assign req          = dmemREN | dmemWEN;
    assign hit          = req && valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign victim_dirty = valid[req_idx] & dirty[req_idx];
    assign flush_dirty  = valid[flush_idx] & dirty[flush_idx];
    // A flush slot retires either immediately (clean line) or when its write completes.
    assign flush_step   = !flush_dirty || !dwait;

    assign flushed = (state == DONE);

    // Requester side completes when dhit=1; memory side completes when dwait=0
    // while dREN or dWEN is held. Request inputs stay stable until dhit.
    always_comb begin
        next_state = state;
        dhit       = 1'b0;
        dmemload   = '0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        dhit = 1'b1;
                        if (!dmemWEN) dmemload = data_arr[req_idx];
                    end else if (victim_dirty) begin
                        next_state = WB;
                    end else begin
                        next_state = FETCH;
                    end
                end else if (halt) begin
                    next_state = FLUSH;
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tag_arr[req_idx], req_idx, 2'b00};
                dstore = data_arr[req_idx];
                if (!dwait) next_state = FETCH;
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {dmemaddr[WORD_W-1:2], 2'b00};
                if (!dwait) next_state = IDLE;
            end
            FLUSH: begin
                if (flush_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {tag_arr[flush_idx], flush_idx, 2'b00};
                    dstore = data_arr[flush_idx];
                end
                if (flush_step && (flush_idx == IDX_W'(SETS - 1))) next_state = DONE;
            end
            DONE: ;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            flush_idx <= '0;
            valid     <= '0;
            dirty     <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_arr[i]  <= '0;
                data_arr[i] <= '0;
            end
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (hit && dmemWEN) begin
                        data_arr[req_idx] <= dmemstore;
                        dirty[req_idx]    <= 1'b1;
                    end else if (!req && halt) begin
                        flush_idx <= '0;
                    end
                end
                WB: begin
                    if (!dwait) dirty[req_idx] <= 1'b0;
                end
                FETCH: begin
                    if (!dwait) begin
                        data_arr[req_idx] <= dload;
                        tag_arr[req_idx]  <= req_tag;
                        valid[req_idx]    <= 1'b1;
                        dirty[req_idx]    <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_step) begin
                        if (flush_dirty) dirty[flush_idx] <= 1'b0;
                        flush_idx <= flush_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed scenarios plus randomized traffic,
// checked cycle by cycle against an array-based cache and memory model.
module tb_dcache_responder;
    localparam int SETS  = 8;
    localparam int IDX_W = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    dcache_responder #(.SETS(SETS), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int fixed_wait = 0;

    logic        m_valid [SETS];
    logic        m_dirty [SETS];
    logic [31:0] m_tag   [SETS];
    logic [31:0] m_data  [SETS];
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic int pick_wait();
        return (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_data[i]  = 32'h0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // Called just after a rising edge with inputs set; checks at the falling edge.
    task automatic cyc(input string nm, input logic e_hit, input logic [31:0] e_load,
                       input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                       input logic [31:0] e_store, input logic e_fl);
        @(negedge CLK);
        chk({nm, ".dhit"},     {31'b0, dhit},    {31'b0, e_hit});
        chk({nm, ".dmemload"}, dmemload,         e_load);
        chk({nm, ".dREN"},     {31'b0, dREN},    {31'b0, e_ren});
        chk({nm, ".dWEN"},     {31'b0, dWEN},    {31'b0, e_wen});
        chk({nm, ".daddr"},    daddr,            e_addr);
        chk({nm, ".dstore"},   dstore,           e_store);
        chk({nm, ".flushed"},  {31'b0, flushed}, {31'b0, e_fl});
        @(posedge CLK);
        #1;
    endtask

    task automatic access(input logic [31:0] addr, input logic ren, input logic wen,
                          input logic [31:0] wdata);
        int          idx, nw;
        logic [31:0] tg, faddr, wbaddr;
        logic        is_hit;
        idx    = (addr >> 2) % SETS;
        tg     = addr >> (IDX_W + 2);
        faddr  = addr & 32'hFFFF_FFFC;
        is_hit = m_valid[idx] && (m_tag[idx] == tg);
        dmemaddr  = addr;
        dmemREN   = ren;
        dmemWEN   = wen;
        dmemstore = wdata;
        if (!is_hit) begin
            dwait = 1'($urandom_range(0, 1));
            cyc("miss_idle", 0, 0, 0, 0, 0, 0, 0);
            if (m_valid[idx] && m_dirty[idx]) begin
                wbaddr = (m_tag[idx] * SETS + idx) * 4;
                nw = pick_wait();
                for (int k = 0; k <= nw; k++) begin
                    dwait = (k < nw);
                    cyc("writeback", 0, 0, 0, 1, wbaddr, m_data[idx], 0);
                end
                mem[wbaddr] = m_data[idx];
                m_dirty[idx] = 1'b0;
            end
            nw = pick_wait();
            for (int k = 0; k <= nw; k++) begin
                dwait = (k < nw);
                dload = (k < nw) ? $urandom : mem_rd(faddr);
                cyc("fetch", 0, 0, 1, 0, faddr, 0, 0);
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = mem_rd(faddr);
        end
        dwait = 1'($urandom_range(0, 1));
        dload = $urandom;
        cyc(wen ? "write_hit" : "read_hit", 1, wen ? 32'h0 : m_data[idx], 0, 0, 0, 0, 0);
        if (wen) begin
            m_data[idx]  = wdata;
            m_dirty[idx] = 1'b1;
        end
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic do_flush();
        logic [31:0] a;
        int          nw;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        halt    = 1'b1;
        cyc("halt_idle", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < SETS; i++) begin
            dmemREN  = 1'($urandom_range(0, 1));
            dmemaddr = $urandom & 32'h0000_00FC;
            halt     = 1'($urandom_range(0, 1));
            if (m_valid[i] && m_dirty[i]) begin
                a  = (m_tag[i] * SETS + i) * 4;
                nw = pick_wait();
                for (int k = 0; k <= nw; k++) begin
                    dwait = (k < nw);
                    cyc("flush_write", 0, 0, 0, 1, a, m_data[i], 0);
                end
                mem[a] = m_data[i];
                m_dirty[i] = 1'b0;
            end else begin
                dwait = 1'($urandom_range(0, 1));
                cyc("flush_skip", 0, 0, 0, 0, 0, 0, 0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            dmemREN = 1'b1;
            dmemWEN = 1'($urandom_range(0, 1));
            cyc("done", 0, 0, 0, 0, 0, 0, 1);
        end
        halt    = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; dwait = 1'b0;
        dmemaddr = 32'h0; dmemstore = 32'h0; dload = 32'h0;
        cyc("reset", 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [31:0] a;
        int          op;

        apply_reset();
        cyc("idle_quiet", 0, 0, 0, 0, 0, 0, 0);

        // Clean read miss then immediate re-read hit
        fixed_wait = 0;
        mem[32'h40] = 32'hDEADBEEF;
        access(32'h40, 1, 0, 0);
        access(32'h40, 1, 0, 0);

        // Write hit, then conflicting read forces a writeback of 0x40
        access(32'h40, 0, 1, 32'h12345678);
        access(32'h60, 1, 0, 0);

        // Read miss with memory busy for five cycles
        fixed_wait = 5;
        access(32'h80, 1, 0, 0);

        // Read and write together on a hit behave as a write
        fixed_wait = 0;
        access(32'h80, 1, 1, 32'hCAFEF00D);
        access(32'h80, 1, 0, 0);

        // Reset while a fetch is stalled abandons it and empties the cache
        dmemaddr = 32'h08; dmemREN = 1'b1; dmemWEN = 1'b0; dwait = 1'b1;
        cyc("r6_miss_idle", 0, 0, 0, 0, 0, 0, 0);
        cyc("r6_fetch", 0, 0, 1, 0, 32'h08, 0, 0);
        #2 nRST = 1'b0;
        #1;
        chk("r6_rst_dREN", {31'b0, dREN}, 32'h0);
        chk("r6_rst_daddr", daddr, 32'h0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        model_clear();
        dmemREN = 1'b0;
        access(32'h08, 1, 0, 0);

        // Randomized traffic over a few tags per index, then a full flush
        fixed_wait = -1;
        for (int n = 0; n < 60; n++) begin
            a  = (32'($urandom_range(0, 3)) * SETS + 32'($urandom_range(0, SETS - 1))) * 4
                 + 32'($urandom_range(0, 3));
            op = $urandom_range(0, 2);
            access(a, op != 1, op != 0, $urandom);
            if ($urandom_range(0, 3) == 0) cyc("gap", 0, 0, 0, 0, 0, 0, 0);
        end
        do_flush();

        // Two dirty lines, flushed in index order with no memory waits
        apply_reset();
        fixed_wait = 0;
        access(32'h04, 0, 1, 32'hA1A1_0004);
        access(32'h14, 0, 1, 32'hB2B2_0014);
        do_flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
